// File: rtl/tetris_pkg.sv
// Shared board geometry, FSM state type and the line-total helper for the
// Tetris map logic.
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int CELL_BITS  = 5;
    localparam int EMPTY_CELL = 0;

    localparam int ROW_W     = 5;
    localparam int LINES_W   = 3;
    localparam int TOTAL_W   = 10;
    localparam int PASS_MAX  = 7;
    localparam int TOTAL_MAX = 999;

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        FILL,
        FIN
    } state_t;

    function automatic logic [TOTAL_W-1:0] sat_total(input logic [TOTAL_W-1:0] total,
                                                     input logic [LINES_W-1:0] n);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, total} + {{(TOTAL_W + 1 - LINES_W){1'b0}}, n};
        return (sum > (TOTAL_W + 1)'(TOTAL_MAX)) ? TOTAL_W'(TOTAL_MAX) : sum[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// A row is full when no cell in it carries the empty colour code.
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int COLS   = BOARD_COLS,
    parameter int CELL_W = CELL_BITS
) (
    input  logic [COLS*CELL_W-1:0] row,
    output logic                   full
);

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row[c*CELL_W +: CELL_W] == CELL_W'(EMPTY_CELL)) full = 1'b0;
        end
    end

endmodule

// File: rtl/row_clear_ctrl.sv
// Clears full rows after a piece locks: walks the map bottom-up copying kept
// rows down over cleared ones, then zero-fills the freed rows at the top.
module row_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS   = BOARD_ROWS,
    parameter int COLS   = BOARD_COLS,
    parameter int CELL_W = CELL_BITS
) (
    input  logic                   VGA_CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   stall,
    output logic [ROW_W-1:0]       rd_row,
    input  logic [COLS*CELL_W-1:0] rd_data,
    output logic                   wr_en,
    output logic [ROW_W-1:0]       wr_row,
    output logic [COLS*CELL_W-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [LINES_W-1:0]     lines,
    output logic [TOTAL_W-1:0]     total_lines,
    output state_t                 state_dbg
);

    // Handshake: start is a one-cycle request sampled only in IDLE with stall low;
    // busy stays high from the next cycle through the done cycle, and done is a
    // single-cycle pulse that never fires while stall is high.

    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   ROW_ONE  = ROW_W'(1);
    localparam logic [LINES_W-1:0] CNT_MAX  = LINES_W'(PASS_MAX);

    state_t             state;
    logic [ROW_W-1:0]   src;
    logic [ROW_W-1:0]   dst;
    logic [LINES_W-1:0] count;
    logic [LINES_W-1:0] count_next;
    logic               row_full;

    row_full_detect #(
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) u_full (
        .row  (rd_data),
        .full (row_full)
    );

    assign count_next = (row_full && count != CNT_MAX) ? count + LINES_W'(1) : count;
    assign rd_row     = src;
    assign done       = (state == FIN) && !stall;
    assign state_dbg  = state;

    // Writes depend on the same-cycle map read, so the strobe is decoded here.
    always_comb begin
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        if (!stall) begin
            case (state)
                COMPACT: begin
                    if (!row_full && src != dst) begin
                        wr_en   = 1'b1;
                        wr_row  = dst;
                        wr_data = rd_data;
                    end
                end
                FILL: begin
                    wr_en  = 1'b1;
                    wr_row = dst;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            src         <= LAST_ROW;
            dst         <= LAST_ROW;
            count       <= '0;
            busy        <= 1'b0;
            lines       <= '0;
            total_lines <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src   <= LAST_ROW;
                        dst   <= LAST_ROW;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= COMPACT;
                    end
                end
                COMPACT: begin
                    count <= count_next;
                    // A cleared row leaves dst in place so the next kept row drops onto it.
                    if (!row_full && dst != '0) dst <= dst - ROW_ONE;
                    if (src == '0) state <= (count_next != '0) ? FILL : FIN;
                    else           src   <= src - ROW_ONE;
                end
                FILL: begin
                    if (dst == '0) state <= FIN;
                    else           dst   <= dst - ROW_ONE;
                end
                FIN: begin
                    lines       <= count;
                    total_lines <= sat_total(total_lines, count);
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Directed bench for row_clear_ctrl driving a behavioural 20x50-bit map.
module tb_row_clear_ctrl;
  import tetris_pkg::*;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int CELL_W = 5;
  localparam int W      = COLS * CELL_W;
  localparam int RECW   = ROW_W + W;

  logic               VGA_CLK = 1'b0;
  logic               RST     = 1'b1;
  logic               start   = 1'b0;
  logic               stall   = 1'b0;
  logic [ROW_W-1:0]   rd_row;
  logic [W-1:0]       rd_data;
  logic               wr_en;
  logic [ROW_W-1:0]   wr_row;
  logic [W-1:0]       wr_data;
  logic               busy;
  logic               done;
  logic [LINES_W-1:0] lines;
  logic [TOTAL_W-1:0] total_lines;
  state_t             state_dbg;

  logic [W-1:0]    board [ROWS];
  logic [RECW-1:0] wr_log [$];
  logic [RECW-1:0] exp_q [$];

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [W-1:0] PAT_A = W'(50'h0_0000_0001_2345);
  localparam logic [W-1:0] PAT_B = W'(50'h0_0003_FF00_0000);

  // clock / reset block
  always #5 VGA_CLK = ~VGA_CLK;

  row_clear_ctrl #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CELL_W (CELL_W)
  ) dut (
    .VGA_CLK     (VGA_CLK),
    .RST         (RST),
    .start       (start),
    .stall       (stall),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .lines       (lines),
    .total_lines (total_lines),
    .state_dbg   (state_dbg)
  );

  assign rd_data = (rd_row < ROW_W'(ROWS)) ? board[rd_row] : '0;

  always @(posedge VGA_CLK) begin
    if (wr_en) begin
      board[wr_row] <= wr_data;
      wr_log.push_back({wr_row, wr_data});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] full_row();
    logic [W-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*CELL_W +: CELL_W] = CELL_W'(c % 7 + 1);
    return r;
  endfunction

  // driver tasks
  task automatic load_board(input int full_lo);
    for (int r = 0; r < ROWS; r++) board[r] <= (r >= full_lo) ? full_row() : '0;
  endtask

  task automatic run_pass(input string name, input int exp_lat, input int exp_lines,
                          input int stall_at, input int stall_len);
    int c;
    int stall_wr;
    wr_log.delete();
    stall_wr = 0;
    start = 1'b1;
    @(negedge VGA_CLK);
    start = 1'b0;
    c = 1;
    check({name, "_busy"}, 64'(busy), 64'd1);
    while (c < 200) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      #1;
      if (stall && wr_en) stall_wr++;
      if (done) break;
      @(negedge VGA_CLK);
      c++;
    end
    stall = 1'b0;
    check({name, "_latency"}, 64'(c), 64'(exp_lat));
    if (stall_len > 0) check({name, "_stall_wr"}, 64'(stall_wr), 64'd0);
    @(negedge VGA_CLK);
    check({name, "_lines"}, 64'(lines), 64'(exp_lines));
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_done_end"}, 64'(done), 64'd0);
    check({name, "_state_end"}, 64'(state_dbg), 64'(IDLE));
  endtask

  task automatic check_writes(input string name);
    check({name, "_wr_cnt"}, 64'(wr_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_log.size()) check({name, "_wr"}, 64'(wr_log[i]), 64'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    // reset values while RST is held
    repeat (2) @(negedge VGA_CLK);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_lines", 64'(lines), 64'd0);
    check("rst_total", 64'(total_lines), 64'd0);
    check("rst_rd_row", 64'(rd_row), 64'd19);
    check("rst_wr_row", 64'(wr_row), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    RST = 1'b0;

    // empty board: 20 compact cycles, no writes, done at cycle 21
    load_board(ROWS);
    run_pass("empty", 21, 0, 0, 0);
    check_writes("empty");
    check("empty_total", 64'(total_lines), 64'd0);

    // row 19 full, row 18 = 0x03: row 18 drops to 19, one zero fill of row 0
    load_board(19);
    board[18] <= W'(3);
    exp_q.push_back({5'd19, W'(3)});
    for (int d = 18; d >= 1; d--) exp_q.push_back({ROW_W'(d), W'(0)});
    exp_q.push_back({5'd0, W'(0)});
    run_pass("one", 22, 1, 0, 0);
    check_writes("one");
    check("one_row19", 64'(board[19]), 64'd3);
    check("one_row18", 64'(board[18]), 64'd0);
    check("one_total", 64'(total_lines), 64'd1);

    // four full rows 16..19: compaction of empties then zero fill of rows 3..0
    load_board(16);
    for (int d = 19; d >= 4; d--) exp_q.push_back({ROW_W'(d), W'(0)});
    for (int d = 3; d >= 0; d--) exp_q.push_back({ROW_W'(d), W'(0)});
    run_pass("four", 25, 4, 0, 0);
    check_writes("four");
    begin
      int nz;
      nz = 0;
      for (int r = 0; r < ROWS; r++) if (board[r] != '0) nz++;
      check("four_board_nz", 64'(nz), 64'd0);
    end
    check("four_total", 64'(total_lines), 64'd5);

    // stall 5 cycles mid-compact: done moves from 22 to 27, same final board
    load_board(19);
    board[10] <= PAT_A;
    board[5]  <= PAT_B;
    run_pass("stall", 27, 1, 5, 5);
    check("stall_row11", 64'(board[11]), 64'(PAT_A));
    check("stall_row6", 64'(board[6]), 64'(PAT_B));
    check("stall_row10", 64'(board[10]), 64'd0);
    check("stall_row19", 64'(board[19]), 64'd0);
    check("stall_total", 64'(total_lines), 64'd6);

    // reset during FILL: 16 compaction writes + 1 fill write survive
    load_board(16);
    board[15] <= PAT_A;
    wr_log.delete();
    start = 1'b1;
    @(negedge VGA_CLK);
    start = 1'b0;
    repeat (21) @(negedge VGA_CLK);
    check("rf_state_fill", 64'(state_dbg), 64'(FILL));
    RST = 1'b1;
    #1;
    check("rf_wr_en", 64'(wr_en), 64'd0);
    check("rf_busy", 64'(busy), 64'd0);
    check("rf_lines", 64'(lines), 64'd0);
    check("rf_total", 64'(total_lines), 64'd0);
    check("rf_state", 64'(state_dbg), 64'(IDLE));
    check("rf_wr_cnt", 64'(wr_log.size()), 64'd17);
    check("rf_row19", 64'(board[19]), 64'(PAT_A));
    check("rf_row3", 64'(board[3]), 64'd0);
    @(negedge VGA_CLK);
    RST = 1'b0;
    run_pass("after_rst", 21, 0, 0, 0);
    check("after_rst_row19", 64'(board[19]), 64'(PAT_A));

    // saturation: 249 x 4 + 2 = 998, then 4 more -> 999, and again -> 999
    for (int p = 0; p < 249; p++) begin
      load_board(16);
      run_pass("sat_fill", 25, 4, 0, 0);
    end
    check("sat_996", 64'(total_lines), 64'd996);
    load_board(18);
    run_pass("sat_two", 23, 2, 0, 0);
    check("sat_998", 64'(total_lines), 64'd998);
    load_board(16);
    run_pass("sat_top", 25, 4, 0, 0);
    check("sat_999", 64'(total_lines), 64'd999);
    load_board(16);
    run_pass("sat_hold", 25, 4, 0, 0);
    check("sat_999_hold", 64'(total_lines), 64'd999);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
